// File: rtl/sisc_mem_arb_if.sv
// Bus bundle between the SISC requesters, the memory-port arbiter and the memory model.
// The slave modport is the arbiter's view; the master modport is the requester/memory side.
interface sisc_mem_arb_if #(
  parameter int AW = 16,
  parameter int DW = 32
) ();
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;

  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_ack;
  logic [DW-1:0] dm_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_ack, if_rdata, dm_ack, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_ack, if_rdata, dm_ack, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/sisc_mem_arb.sv
// Fetch/data arbiter in front of one single-ported fixed-latency memory; all outputs registered.
// Define SISC_ARB_RR_EN for round-robin tie-breaking; otherwise data always beats fetch.
module sisc_mem_arb #(
  parameter int AW      = 16,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst_f,
  sisc_mem_arb_if.slave bus
);

  localparam int CW = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_RESP
  } state_e;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_DM = 1'b1
  } req_e;

  state_e        state_q,     state_d;
  req_e          win_q,       win_d;
  logic          we_q,        we_d;
  logic [AW-1:0] addr_q,      addr_d;
  logic [DW-1:0] wdata_q,     wdata_d;
  logic [CW-1:0] cnt_q,       cnt_d;
  logic          mem_en_q,    mem_en_d;
  logic          mem_we_q,    mem_we_d;
  logic          if_ack_q,    if_ack_d;
  logic          dm_ack_q,    dm_ack_d;
  logic [DW-1:0] if_rdata_q,  if_rdata_d;
  logic [DW-1:0] dm_rdata_q,  dm_rdata_d;
  logic          busy_q,      busy_d;
  logic          pick_dm;

`ifdef SISC_ARB_RR_EN
  req_e          last_q,      last_d;
`endif

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path leaves one unassigned and infers a latch.
    state_d    = state_q;
    win_d      = win_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;

`ifdef SISC_ARB_RR_EN
    last_d  = last_q;
    // On a tie the requester that did not win last time is granted.
    pick_dm = bus.dm_req && (!bus.if_req || (last_q == REQ_IF));
`else
    pick_dm = bus.dm_req;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.if_req || bus.dm_req) begin
          win_d   = pick_dm ? REQ_DM : REQ_IF;
          addr_d  = pick_dm ? bus.dm_addr : bus.if_addr;
          we_d    = pick_dm && bus.dm_we;
          wdata_d = pick_dm ? bus.dm_wdata : '0;
          state_d = S_ACCESS;
`ifdef SISC_ARB_RR_EN
          last_d  = pick_dm ? REQ_DM : REQ_IF;
`endif
        end
      end
      S_ACCESS: begin
        if (we_q) begin
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
          cnt_d   = CW'(MEM_LAT - 1);
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          if (win_q == REQ_DM) dm_rdata_d = bus.mem_rdata;
          else                 if_rdata_d = bus.mem_rdata;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they appear registered in the state they belong to.
    mem_en_d = (state_d == S_ACCESS);
    mem_we_d = (state_d == S_ACCESS) && we_d;
    if_ack_d = (state_d == S_RESP) && (win_d == REQ_IF);
    dm_ack_d = (state_d == S_RESP) && (win_d == REQ_DM);
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (rst_f) begin
      state_q    <= S_IDLE;
      win_q      <= REQ_IF;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      busy_q     <= 1'b0;
`ifdef SISC_ARB_RR_EN
      last_q     <= REQ_IF;
`endif
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      if_ack_q   <= if_ack_d;
      dm_ack_q   <= dm_ack_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      busy_q     <= busy_d;
`ifdef SISC_ARB_RR_EN
      last_q     <= last_d;
`endif
    end
  end

  // Address and write data come straight from the request latches.
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.dm_ack    = dm_ack_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_sisc_mem_arb.sv
// Self-checking bench for sisc_mem_arb: scoreboarded table vectors plus hand-written
// contention, reset-abort, dropped-request and latency-corner sequences.
module tb_sisc_mem_arb;

  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic clk   = 1'b0;
  logic rst_f = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  sisc_mem_arb_if #(.AW(AW), .DW(DW)) m   ();
  sisc_mem_arb_if #(.AW(AW), .DW(DW)) a1  ();
  sisc_mem_arb_if #(.AW(AW), .DW(DW)) a15 ();

  sisc_mem_arb #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) u_dut   (.clk(clk), .rst_f(rst_f), .bus(m));
  sisc_mem_arb #(.AW(AW), .DW(DW), .MEM_LAT(1))   u_dut1  (.clk(clk), .rst_f(rst_f), .bus(a1));
  sisc_mem_arb #(.AW(AW), .DW(DW), .MEM_LAT(15))  u_dut15 (.clk(clk), .rst_f(rst_f), .bus(a15));

  // Main memory model: 256-word array, read data valid exactly LAT cycles after the mem_en cycle.
  logic [DW-1:0] mem     [0:255];
  logic [DW:0]   pipe_m  [0:LAT-1];
  logic [DW:0]   pipe_1  [0:0];
  logic [DW:0]   pipe_15 [0:14];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] <= (i == 16) ? 32'hDEADBEEF : (32'hC0DE0000 | i);
  end

  always @(posedge clk) begin
    if (m.mem_en && m.mem_we) mem[m.mem_addr[7:0]] <= m.mem_wdata;
    pipe_m[0] <= {m.mem_en && !m.mem_we, mem[m.mem_addr[7:0]]};
    for (int i = 1; i < LAT; i++) pipe_m[i] <= pipe_m[i-1];
    pipe_1[0]  <= {a1.mem_en && !a1.mem_we, a1.mem_addr, ~a1.mem_addr};
    pipe_15[0] <= {a15.mem_en && !a15.mem_we, a15.mem_addr, ~a15.mem_addr};
    for (int i = 1; i < 15; i++) pipe_15[i] <= pipe_15[i-1];
  end

  // Outside the valid cycle the memory drives a poison value, so an off-by-one capture shows up.
  assign m.mem_rdata   = pipe_m[LAT-1][DW] ? pipe_m[LAT-1][DW-1:0] : 32'hBAD0BAD0;
  assign a1.mem_rdata  = pipe_1[0][DW]     ? pipe_1[0][DW-1:0]     : 32'hBAD0BAD0;
  assign a15.mem_rdata = pipe_15[14][DW]   ? pipe_15[14][DW-1:0]   : 32'hBAD0BAD0;

  typedef struct {
    int            cyc;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mem_exp_t;

  typedef struct {
    int            cyc;
    logic          is_dm;
    logic [DW-1:0] rdata;
  } ack_exp_t;

  typedef struct {
    logic          is_dm;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rd;
    int            ack_off;
  } vec_t;

  mem_exp_t mem_q [$];
  ack_exp_t ack_q [$];
  vec_t     vecs  [9];

  logic [DW-1:0] if_last;
  logic [DW-1:0] dm_last;
  logic          rr_last_dm;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected memory access and acknowledge for one transaction, in service order.
  task automatic push_txn(input logic is_dm, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rd,
                          input int mem_cyc, input int ack_cyc);
    mem_exp_t me;
    ack_exp_t ae;
    me.cyc = mem_cyc; me.we = we; me.addr = addr; me.wdata = wdata;
    mem_q.push_back(me);
    if (!we) begin
      if (is_dm) dm_last = exp_rd;
      else       if_last = exp_rd;
    end
    ae.cyc   = ack_cyc;
    ae.is_dm = is_dm;
    ae.rdata = is_dm ? dm_last : if_last;
    ack_q.push_back(ae);
    rr_last_dm = is_dm;
  endtask

  always @(negedge clk) begin
    mem_exp_t me;
    ack_exp_t ae;
    if (m.mem_en) begin
      if (mem_q.size() == 0) check("mem_en_spurious", 64'(m.mem_en), 64'd0);
      else begin
        me = mem_q.pop_front();
        check("mem_en_cycle", 64'(cyc), 64'(me.cyc));
        check("mem_we", 64'(m.mem_we), 64'(me.we));
        check("mem_addr", 64'(m.mem_addr), 64'(me.addr));
        if (me.we) check("mem_wdata", 64'(m.mem_wdata), 64'(me.wdata));
      end
    end
    if (m.if_ack || m.dm_ack) begin
      if (ack_q.size() == 0) check("ack_spurious", 64'({m.if_ack, m.dm_ack}), 64'd0);
      else begin
        ae = ack_q.pop_front();
        check("ack_cycle", 64'(cyc), 64'(ae.cyc));
        check("ack_who", 64'({m.if_ack, m.dm_ack}), ae.is_dm ? 64'd1 : 64'd2);
        check("ack_rdata", ae.is_dm ? 64'(m.dm_rdata) : 64'(m.if_rdata), 64'(ae.rdata));
      end
    end
  end

  task automatic req_if(input logic [AW-1:0] addr);
    int n = 0;
    m.if_addr = addr;
    m.if_req  = 1'b1;
    while (!m.if_ack && n < 40) begin @(negedge clk); n++; end
    check("if_ack_timeout", 64'(n >= 40), 64'd0);
    m.if_req = 1'b0;
  endtask

  task automatic req_dm(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    int n = 0;
    m.dm_we    = we;
    m.dm_addr  = addr;
    m.dm_wdata = wdata;
    m.dm_req   = 1'b1;
    while (!m.dm_ack && n < 40) begin @(negedge clk); n++; end
    check("dm_ack_timeout", 64'(n >= 40), 64'd0);
    m.dm_req = 1'b0;
  endtask

  // Both requesters raise reads in the same cycle; the loser starts 5 cycles after the winner.
  task automatic run_pair(input logic [AW-1:0] d_addr, input logic [DW-1:0] d_exp,
                          input logic [AW-1:0] i_addr, input logic [DW-1:0] i_exp);
    logic dm_first;
    int   t0;
    @(posedge clk); #1;
    t0 = cyc;
`ifdef SISC_ARB_RR_EN
    dm_first = !rr_last_dm;
`else
    dm_first = 1'b1;
`endif
    if (dm_first) begin
      push_txn(1'b1, 1'b0, d_addr, '0, d_exp, t0 + 1, t0 + 4);
      push_txn(1'b0, 1'b0, i_addr, '0, i_exp, t0 + 6, t0 + 9);
    end else begin
      push_txn(1'b0, 1'b0, i_addr, '0, i_exp, t0 + 1, t0 + 4);
      push_txn(1'b1, 1'b0, d_addr, '0, d_exp, t0 + 6, t0 + 9);
    end
    fork
      req_dm(1'b0, d_addr, '0);
      req_if(i_addr);
    join
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_mem_en"},    64'(m.mem_en),    64'd0);
    check({tag, "_mem_we"},    64'(m.mem_we),    64'd0);
    check({tag, "_mem_addr"},  64'(m.mem_addr),  64'd0);
    check({tag, "_mem_wdata"}, 64'(m.mem_wdata), 64'd0);
    check({tag, "_acks"},      64'({m.if_ack, m.dm_ack}), 64'd0);
    check({tag, "_if_rdata"},  64'(m.if_rdata),  64'd0);
    check({tag, "_dm_rdata"},  64'(m.dm_rdata),  64'd0);
    check({tag, "_busy"},      64'(m.busy),      64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int            t0, n, c1, c15, acks;
    logic [DW-1:0] d1, d15;

    // {is_dm, we, addr, wdata, expected read data, ack offset from request cycle}
    vecs[0] = '{1'b1, 1'b1, 16'h0020, 32'h12345678, 32'h0,        2};
    vecs[1] = '{1'b1, 1'b0, 16'h0020, 32'h0,        32'h12345678, 4};
    vecs[2] = '{1'b0, 1'b0, 16'h0020, 32'h0,        32'h12345678, 4};
    vecs[3] = '{1'b1, 1'b1, 16'h0030, 32'hA5A50F0F, 32'h0,        2};
    vecs[4] = '{1'b1, 1'b0, 16'h0030, 32'h0,        32'hA5A50F0F, 4};
    vecs[5] = '{1'b1, 1'b1, 16'hFFFF, 32'hFFFFFFFF, 32'h0,        2};
    vecs[6] = '{1'b0, 1'b0, 16'hFFFF, 32'h0,        32'hFFFFFFFF, 4};
    vecs[7] = '{1'b0, 1'b0, 16'h00FE, 32'h0,        32'hC0DE00FE, 4};
    vecs[8] = '{1'b1, 1'b0, 16'h0000, 32'h0,        32'hC0DE0000, 4};

    m.if_req = 1'b0;   m.if_addr = '0;  m.dm_req = 1'b0;  m.dm_we = 1'b0;
    m.dm_addr = '0;    m.dm_wdata = '0;
    a1.if_req = 1'b0;  a1.if_addr = '0; a1.dm_req = 1'b0; a1.dm_we = 1'b0;
    a1.dm_addr = '0;   a1.dm_wdata = '0;
    a15.if_req = 1'b0; a15.if_addr = '0; a15.dm_req = 1'b0; a15.dm_we = 1'b0;
    a15.dm_addr = '0;  a15.dm_wdata = '0;
    if_last = '0; dm_last = '0; rr_last_dm = 1'b0;

    rst_f = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_f = 1'b0;
    @(negedge clk);
    check_zero("reset");

    // Single fetch read with busy traced cycle by cycle.
    @(posedge clk); #1;
    t0 = cyc;
    push_txn(1'b0, 1'b0, 16'h0010, '0, 32'hDEADBEEF, t0 + 1, t0 + 4);
    m.if_addr = 16'h0010;
    m.if_req  = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      check("busy_trace", 64'(m.busy), 64'((cyc >= t0 + 1) && (cyc <= t0 + 4)));
      if (m.if_ack) m.if_req = 1'b0;
    end

    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      push_txn(vecs[i].is_dm, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd,
               cyc + 1, cyc + vecs[i].ack_off);
      if (vecs[i].is_dm) req_dm(vecs[i].we, vecs[i].addr, vecs[i].wdata);
      else               req_if(vecs[i].addr);
    end

    run_pair(16'h0030, 32'hA5A50F0F, 16'h0040, 32'hC0DE0040);
    run_pair(16'h0020, 32'h12345678, 16'h0010, 32'hDEADBEEF);

    // Data requester drops its read during WAIT: still acked, no second access.
    @(posedge clk); #1;
    t0 = cyc;
    push_txn(1'b1, 1'b0, 16'h0020, '0, 32'h12345678, t0 + 1, t0 + 4);
    m.dm_we = 1'b0; m.dm_addr = 16'h0020; m.dm_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    m.dm_req = 1'b0;
    n = 0;
    while (!m.dm_ack && n < 20) begin @(negedge clk); n++; end
    check("dm_ack_after_drop", 64'(m.dm_ack), 64'd1);
    repeat (6) @(negedge clk);

    // Reset while a fetch read sits in WAIT: aborted with no ack.
    @(posedge clk); #1;
    t0 = cyc;
    begin
      mem_exp_t me;
      me.cyc = t0 + 1; me.we = 1'b0; me.addr = 16'h0044; me.wdata = '0;
      mem_q.push_back(me);
    end
    m.if_addr = 16'h0044; m.if_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_f = 1'b1; m.if_req = 1'b0;
    @(posedge clk); #1;
    rst_f = 1'b0;
    @(negedge clk);
    check_zero("midreset");
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (m.if_ack || m.dm_ack) acks++;
    end
    check("no_ack_after_reset", 64'(acks), 64'd0);
    if_last = '0; dm_last = '0; rr_last_dm = 1'b0;
    @(posedge clk); #1;
    push_txn(1'b0, 1'b0, 16'h0040, '0, 32'hC0DE0040, cyc + 1, cyc + 4);
    req_if(16'h0040);

    // Latency corners: MEM_LAT=1 data read and MEM_LAT=15 fetch read in parallel.
    @(posedge clk); #1;
    t0 = cyc; c1 = -1; c15 = -1; d1 = '0; d15 = '0;
    a1.dm_we = 1'b0;  a1.dm_addr = 16'h1234; a1.dm_req = 1'b1;
    a15.if_addr = 16'hBEEF; a15.if_req = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (a1.dm_ack && c1 < 0)   begin c1 = cyc;  d1 = a1.dm_rdata;  a1.dm_req = 1'b0;  end
      if (a15.if_ack && c15 < 0) begin c15 = cyc; d15 = a15.if_rdata; a15.if_req = 1'b0; end
    end
    check("lat1_ack_cycle",  64'(c1),  64'(t0 + 3));
    check("lat1_rdata",      64'(d1),  64'h1234EDCB);
    check("lat15_ack_cycle", 64'(c15), 64'(t0 + 17));
    check("lat15_rdata",     64'(d15), 64'hBEEF4110);

    repeat (3) @(negedge clk);
    check("mem_q_left", 64'(mem_q.size()), 64'd0);
    check("ack_q_left", 64'(ack_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
